// File: rtl/video_stream_checker.sv
// AXI4-Stream RGB video sink: measures frame geometry from tuser/tlast,
// flags framing errors and optionally checks the three-colour test pattern.
module video_stream_checker #(
  parameter int DATAW = 32,
  parameter int SCRW  = 1280,
  parameter int SCRH  = 720
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             stall,
  input  logic             clr,
  input  logic             chk_pat,
  input  logic [12:0]      exp_w,
  input  logic [12:0]      exp_h,
  input  logic [DATAW-1:0] s_axis_tdata,
  input  logic             s_axis_tvalid,
  output logic             s_axis_tready,
  input  logic             s_axis_tuser,
  input  logic             s_axis_tlast,
  output logic [12:0]      meas_w,
  output logic [12:0]      meas_h,
  output logic [15:0]      frame_cnt,
  output logic             frame_done,
  output logic             err_line,
  output logic             err_sof,
  output logic             err_nosof,
  output logic [15:0]      pix_err_cnt,
  output logic             locked
);

  typedef enum logic {
    WAIT_SOF,
    IN_FRAME
  } state_t;

  localparam logic [12:0] SCRW_C = 13'(SCRW);
  localparam logic [12:0] SCRH_C = 13'(SCRH);

  state_t      state_q;
  logic        tready_q;
  logic [12:0] x_q, y_q;
  logic [12:0] x_d, y_d;
  logic        frame_err_q, frame_pix_q;
  logic        good_q, locked_q;
  logic [12:0] meas_w_q, meas_h_q;
  logic [15:0] fcnt_q, pcnt_q;
  logic        done_q;
  logic        eline_q, esof_q, enosof_q;

  logic [12:0] w_s, h_s, px, py;
  logic [13:0] len;
  logic [23:0] exp_pix;
  logic        acc, in_fr, pix_v, nosof, sof_err;
  logic        eol, line_bad, done, mism;
  logic        f_err, f_pix, bad_ev;

  if (DATAW > 24) begin : g_hi
    logic unused_hi;
    assign unused_hi = ^s_axis_tdata[DATAW-1:24];
  end

  assign w_s = (exp_w == '0) ? SCRW_C : exp_w;
  assign h_s = (exp_h == '0) ? SCRH_C : exp_h;

  assign acc   = s_axis_tvalid & tready_q & en & ~clr;
  assign in_fr = (state_q == IN_FRAME);
  assign pix_v = acc & (in_fr | s_axis_tuser);
  assign nosof = acc & ~in_fr & ~s_axis_tuser;
  assign sof_err = acc & in_fr & s_axis_tuser
                 & ((x_q != '0) | (y_q != '0));

  // A tuser beat is always pixel (0,0), whatever the counters say
  assign px  = s_axis_tuser ? '0 : x_q;
  assign py  = s_axis_tuser ? '0 : y_q;
  assign len = {1'b0, px} + 14'd1;

  assign eol      = pix_v & s_axis_tlast;
  assign line_bad = eol & (len != {1'b0, w_s});
  assign done     = eol & (py == h_s - 13'd1);

  always_comb begin
    exp_pix = 24'hFF0000;
    if (py < (h_s >> 1))
      exp_pix = 24'h0000FF;
    else if (px < (w_s >> 1))
      exp_pix = 24'h00FF00;
  end

  assign mism = pix_v & chk_pat
              & (s_axis_tdata[23:0] != exp_pix);

  assign f_err  = (frame_err_q & ~s_axis_tuser) | line_bad;
  assign f_pix  = (frame_pix_q & ~s_axis_tuser) | mism;
  assign bad_ev = sof_err | nosof | line_bad | mism;

  assign x_d = s_axis_tlast ? '0
             : ((&px) ? px : px + 13'd1);
  assign y_d = s_axis_tlast
             ? (done ? '0 : py + 13'd1)
             : py;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= WAIT_SOF;
      tready_q    <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      frame_err_q <= 1'b0;
      frame_pix_q <= 1'b0;
      good_q      <= 1'b0;
      locked_q    <= 1'b0;
      meas_w_q    <= '0;
      meas_h_q    <= '0;
      fcnt_q      <= '0;
      pcnt_q      <= '0;
      done_q      <= 1'b0;
      eline_q     <= 1'b0;
      esof_q      <= 1'b0;
      enosof_q    <= 1'b0;
    end else begin
      tready_q <= en & ~stall;
      done_q   <= 1'b0;
      if (clr || !en) begin
        state_q     <= WAIT_SOF;
        x_q         <= '0;
        y_q         <= '0;
        frame_err_q <= 1'b0;
        frame_pix_q <= 1'b0;
        good_q      <= 1'b0;
        locked_q    <= 1'b0;
        if (clr) begin
          eline_q  <= 1'b0;
          esof_q   <= 1'b0;
          enosof_q <= 1'b0;
          fcnt_q   <= '0;
          pcnt_q   <= '0;
        end
      end else begin
        if (pix_v) begin
          state_q     <= done ? WAIT_SOF : IN_FRAME;
          x_q         <= x_d;
          y_q         <= y_d;
          frame_err_q <= f_err & ~done;
          frame_pix_q <= f_pix & ~done;
        end
        if (sof_err) begin
          esof_q   <= 1'b1;
          meas_h_q <= y_q;
        end
        if (eol)
          meas_w_q <= (&px) ? px : len[12:0];
        if (line_bad)
          eline_q <= 1'b1;
        if (nosof)
          enosof_q <= 1'b1;
        if (mism && !(&pcnt_q))
          pcnt_q <= pcnt_q + 16'd1;
        if (done) begin
          meas_h_q <= h_s;
          done_q   <= 1'b1;
          if (!f_err)
            fcnt_q <= fcnt_q + 16'd1;
          if (!f_err && !f_pix) begin
            locked_q <= good_q;
            good_q   <= 1'b1;
          end
        end
        if (bad_ev) begin
          locked_q <= 1'b0;
          good_q   <= 1'b0;
        end
      end
    end
  end

  assign s_axis_tready = tready_q;
  assign meas_w        = meas_w_q;
  assign meas_h        = meas_h_q;
  assign frame_cnt     = fcnt_q;
  assign frame_done    = done_q;
  assign err_line      = eline_q;
  assign err_sof       = esof_q;
  assign err_nosof     = enosof_q;
  assign pix_err_cnt   = pcnt_q;
  assign locked        = locked_q;

endmodule

// File: tb/tb_video_stream_checker.sv
// Bench for video_stream_checker: vector table, corner sequences and
// randomized frames scored against a frame-level reference model.
module tb_video_stream_checker;

  logic        clk = 1'b0;
  logic        rstn, en, stall, clr, chk_pat;
  logic [12:0] exp_w, exp_h;
  logic [31:0] s_axis_tdata;
  logic        s_axis_tvalid, s_axis_tready;
  logic        s_axis_tuser, s_axis_tlast;
  logic [12:0] meas_w, meas_h;
  logic [15:0] frame_cnt, pix_err_cnt;
  logic        frame_done, err_line, err_sof;
  logic        err_nosof, locked;

  always #5 clk = ~clk;

  video_stream_checker dut (
    .clk           (clk),
    .rstn          (rstn),
    .en            (en),
    .stall         (stall),
    .clr           (clr),
    .chk_pat       (chk_pat),
    .exp_w         (exp_w),
    .exp_h         (exp_h),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tlast  (s_axis_tlast),
    .meas_w        (meas_w),
    .meas_h        (meas_h),
    .frame_cnt     (frame_cnt),
    .frame_done    (frame_done),
    .err_line      (err_line),
    .err_sof       (err_sof),
    .err_nosof     (err_nosof),
    .pix_err_cnt   (pix_err_cnt),
    .locked        (locked)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm,
                     input longint act,
                     input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, exp);
    end
  endtask

  // reference model state
  bit m_infr, m_ferr, m_fpix, m_prev, m_lock;
  bit m_el, m_es, m_ens;
  int mx, my, m_mw, m_mh, m_fcnt, m_pix;
  int m_done = 0;
  int obs_done = 0;

  function automatic logic [23:0] pat(int x, int y,
                                      int w, int h);
    if (y < h / 2) return 24'h0000FF;
    if (x < w / 2) return 24'h00FF00;
    return 24'hFF0000;
  endfunction

  task automatic model_clear(input bit c);
    m_infr = 0; mx = 0; my = 0;
    m_ferr = 0; m_fpix = 0;
    m_lock = 0; m_prev = 0;
    if (c) begin
      m_el = 0; m_es = 0; m_ens = 0;
      m_fcnt = 0; m_pix = 0;
    end
  endtask

  task automatic model_reset();
    model_clear(1);
    m_mw = 0; m_mh = 0;
  endtask

  task automatic model_beat(input logic [31:0] d,
                            input logic u,
                            input logic l);
    int w, h;
    w = (exp_w == 0) ? 1280 : int'(exp_w);
    h = (exp_h == 0) ? 720 : int'(exp_h);
    if (!m_infr && !u) begin
      m_ens = 1; m_lock = 0; m_prev = 0;
      return;
    end
    if (u) begin
      if (m_infr && (mx != 0 || my != 0)) begin
        m_es = 1; m_mh = my;
        m_lock = 0; m_prev = 0;
      end
      mx = 0; my = 0; m_infr = 1;
      m_ferr = 0; m_fpix = 0;
    end
    if (chk_pat && d[23:0] != pat(mx, my, w, h)) begin
      if (m_pix < 65535) m_pix++;
      m_fpix = 1; m_lock = 0; m_prev = 0;
    end
    if (l) begin
      m_mw = (mx + 1 > 8191) ? 8191 : mx + 1;
      if (mx + 1 != w) begin
        m_el = 1; m_ferr = 1;
        m_lock = 0; m_prev = 0;
      end
      if (my == h - 1) begin
        m_mh = h;
        m_done++;
        if (!m_ferr) m_fcnt = (m_fcnt + 1) % 65536;
        if (!m_ferr && !m_fpix) begin
          m_lock = m_prev; m_prev = 1;
        end
        m_infr = 0; mx = 0; my = 0;
      end else begin
        mx = 0; my++;
      end
    end else if (mx < 8191) begin
      mx++;
    end
  endtask

  // inputs change only at posedge+1, so negedge sees the sampled values
  initial forever begin
    @(negedge clk);
    if (!rstn) model_reset();
    else begin
      if (frame_done) obs_done++;
      if (clr || !en) model_clear(clr);
      else if (s_axis_tvalid && s_axis_tready)
        model_beat(s_axis_tdata, s_axis_tuser,
                   s_axis_tlast);
    end
  end

  bit stall_tog = 0;
  bit stall_man = 0;
  bit gap_en = 0;
  int scnt = 0;

  initial forever begin
    @(posedge clk); #1;
    scnt++;
    if (stall_tog) begin
      if (scnt % 3 == 0) stall = ~stall;
    end else begin
      stall = stall_man;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic settle();
    repeat (2) @(negedge clk);
  endtask

  task automatic send_beat(input logic [23:0] p,
                           input logic u,
                           input logic l);
    logic [31:0] r;
    int n;
    if (gap_en)
      while ($urandom_range(0, 2) == 0) tick();
    r = $urandom;
    s_axis_tdata  = {r[7:0], p};
    s_axis_tuser  = u;
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (s_axis_tready) break;
      n++;
      if (n > 200) begin
        checks++; errors++;
        $display("FAIL beat_timeout: tready low %0d cycles", n);
        break;
      end
    end
    tick();
    s_axis_tvalid = 1'b0;
    s_axis_tuser  = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  // fault 1: early tlast, 2: wrong pixel, 3: stop before (fx,fy)
  task automatic send_frame(input int fw, input int fh,
                            input int pw, input int ph,
                            input int fault,
                            input int fx, input int fy,
                            input bit skip);
    logic [23:0] d;
    logic u, l;
    for (int y = 0; y < fh; y++) begin
      for (int x = 0; x < fw; x++) begin
        if (skip && x == 0 && y == 0) continue;
        d = pat(x, y, pw, ph);
        u = (x == 0 && y == 0);
        l = (x == fw - 1);
        if (x == fx && y == fy) begin
          if (fault == 3) return;
          if (fault == 2) d = 24'h00FF00;
          if (fault == 1) begin
            send_beat(d, u, 1'b1);
            break;
          end
        end
        send_beat(d, u, l);
      end
    end
  endtask

  task automatic setup(input int ew, input int eh,
                       input bit ck);
    en = 1'b0;
    tick();
    exp_w = 13'(ew);
    exp_h = 13'(eh);
    chk_pat = ck;
    en = 1'b1;
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic cmp_model(input string t);
    chk({t, " meas_w"}, meas_w, m_mw);
    chk({t, " meas_h"}, meas_h, m_mh);
    chk({t, " frame_cnt"}, frame_cnt, m_fcnt);
    chk({t, " err_line"}, err_line, m_el);
    chk({t, " err_sof"}, err_sof, m_es);
    chk({t, " err_nosof"}, err_nosof, m_ens);
    chk({t, " pix_err_cnt"}, pix_err_cnt, m_pix);
    chk({t, " locked"}, locked, m_lock);
    chk({t, " done_pulses"}, obs_done, m_done);
  endtask

  typedef struct {
    int ew, eh, fw, fh, ck, nfr;
    int fault, fx, fy;
    int fcnt, mw, mh, el, pix, lock, dn;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int base, pw, ph, w, h, k;
    vecs[0] = '{8,4,8,4,1,2,0,0,0, 2,8,4,0,0,1,2};
    vecs[1] = '{8,4,8,4,1,1,1,5,3, 0,6,4,1,0,0,1};
    vecs[2] = '{8,4,8,4,1,1,1,5,2, 0,8,4,1,0,0,1};
    vecs[3] = '{8,4,8,4,1,1,2,6,3, 1,8,4,0,1,0,1};
    vecs[4] = '{8,4,8,4,0,1,2,6,3, 1,8,4,0,0,0,1};
    vecs[5] = '{0,4,8,1,0,1,0,0,0, 0,8,-1,1,0,0,0};
    vecs[6] = '{8,0,8,2,0,1,0,0,0, 0,8,-1,0,0,0,0};
    vecs[7] = '{4,2,4,2,1,3,0,0,0, 3,4,2,0,0,1,3};
    vecs[8] = '{1,2,1,2,1,2,0,0,0, 2,1,2,0,0,1,2};

    rstn = 1'b0; en = 1'b0; stall = 1'b0; clr = 1'b0;
    chk_pat = 1'b0; exp_w = '0; exp_h = '0;
    s_axis_tdata = '0; s_axis_tvalid = 1'b0;
    s_axis_tuser = 1'b0; s_axis_tlast = 1'b0;
    repeat (3) tick();
    chk("rst tready", s_axis_tready, 0);
    chk("rst meas_w", meas_w, 0);
    chk("rst meas_h", meas_h, 0);
    chk("rst frame_cnt", frame_cnt, 0);
    chk("rst pix_err_cnt", pix_err_cnt, 0);
    chk("rst errs", {err_line, err_sof, err_nosof}, 0);
    chk("rst locked", locked, 0);
    chk("rst frame_done", frame_done, 0);
    rstn = 1'b1;
    tick();

    // tready: registered, one cycle behind en/stall
    chk("tready en0", s_axis_tready, 0);
    en = 1'b1;
    @(negedge clk);
    chk("tready latency", s_axis_tready, 0);
    tick();
    @(negedge clk);
    chk("tready en1", s_axis_tready, 1);
    tick();
    stall_man = 1;
    tick(); tick();
    @(negedge clk);
    chk("tready stall", s_axis_tready, 0);
    tick();
    stall_man = 0;
    tick(); tick();
    @(negedge clk);
    chk("tready unstall", s_axis_tready, 1);
    tick();

    foreach (vecs[i]) begin
      vec_t v;
      string t;
      v = vecs[i];
      t = $sformatf("vec%0d", i);
      setup(v.ew, v.eh, v.ck[0]);
      base = obs_done;
      pw = (v.ew == 0) ? 1280 : v.ew;
      ph = (v.eh == 0) ? 720 : v.eh;
      for (int f = 0; f < v.nfr; f++)
        send_frame(v.fw, v.fh, pw, ph,
                   (f == 0) ? v.fault : 0,
                   v.fx, v.fy, 0);
      settle();
      chk({t, " frame_cnt"}, frame_cnt, v.fcnt);
      chk({t, " meas_w"}, meas_w, v.mw);
      if (v.mh >= 0) chk({t, " meas_h"}, meas_h, v.mh);
      chk({t, " err_line"}, err_line, v.el);
      chk({t, " err_sof"}, err_sof, 0);
      chk({t, " err_nosof"}, err_nosof, 0);
      chk({t, " pix_err_cnt"}, pix_err_cnt, v.pix);
      chk({t, " locked"}, locked, v.lock);
      chk({t, " done"}, obs_done - base, v.dn);
      cmp_model(t);
    end

    // stall every 3 cycles plus random tvalid gaps
    setup(8, 4, 1);
    base = obs_done;
    stall_tog = 1; gap_en = 1;
    send_frame(8, 4, 8, 4, 0, 0, 0, 0);
    send_frame(8, 4, 8, 4, 0, 0, 0, 0);
    stall_tog = 0; gap_en = 0;
    settle();
    chk("stall frame_cnt", frame_cnt, 2);
    chk("stall locked", locked, 1);
    chk("stall meas_w", meas_w, 8);
    chk("stall done", obs_done - base, 2);
    cmp_model("stall");

    // tuser at (3,1) aborts the frame and starts a new one
    setup(8, 4, 1);
    send_frame(8, 4, 8, 4, 3, 3, 1, 0);
    send_beat(pat(0, 0, 8, 4), 1'b1, 1'b0);
    settle();
    chk("sof err_sof", err_sof, 1);
    chk("sof meas_h", meas_h, 1);
    chk("sof frame_cnt", frame_cnt, 0);
    tick();
    send_frame(8, 4, 8, 4, 0, 0, 0, 1);
    send_frame(8, 4, 8, 4, 0, 0, 0, 0);
    settle();
    chk("sof2 frame_cnt", frame_cnt, 2);
    chk("sof2 locked", locked, 1);
    chk("sof2 meas_h", meas_h, 4);
    cmp_model("sof");

    // no tuser, then reset mid-frame, then clr
    setup(8, 4, 1);
    repeat (3) send_beat(pat(3, 1, 8, 4), 1'b0, 1'b0);
    settle();
    chk("nosof flag", err_nosof, 1);
    chk("nosof frame_cnt", frame_cnt, 0);
    tick();
    send_frame(8, 4, 8, 4, 3, 2, 1, 0);
    rstn = 1'b0;
    #2;
    chk("arst meas_w", meas_w, 0);
    chk("arst meas_h", meas_h, 0);
    chk("arst err_nosof", err_nosof, 0);
    chk("arst tready", s_axis_tready, 0);
    chk("arst locked", locked, 0);
    tick(); tick();
    rstn = 1'b1;
    tick();
    repeat (2) send_beat(pat(4, 1, 8, 4), 1'b0, 1'b0);
    send_frame(8, 4, 8, 4, 0, 0, 0, 0);
    settle();
    chk("post frame_cnt", frame_cnt, 1);
    chk("post meas_w", meas_w, 8);
    chk("post err_nosof", err_nosof, 1);
    cmp_model("postrst");
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    settle();
    chk("clr frame_cnt", frame_cnt, 0);
    chk("clr err_nosof", err_nosof, 0);
    chk("clr meas_w", meas_w, 8);
    cmp_model("clr");

    // randomized frames with injected faults
    for (int r = 0; r < 10; r++) begin
      tick();
      en = 1'b0;
      tick();
      w = $urandom_range(2, 8);
      h = $urandom_range(2, 5);
      exp_w = 13'(w);
      exp_h = 13'(h);
      chk_pat = 1'($urandom_range(0, 1));
      stall_tog = 1'($urandom_range(0, 1));
      gap_en = 1;
      en = 1'b1;
      tick();
      for (int f = 0; f < 4; f++) begin
        k = $urandom_range(0, 7);
        case (k)
          0: send_frame(w, h, w, h, 1,
                        $urandom_range(0, w - 1),
                        $urandom_range(0, h - 1), 0);
          1: send_frame(w, h, w, h, 2,
                        $urandom_range(0, w - 1),
                        $urandom_range(0, h - 1), 0);
          2: begin
            send_beat(24'h123456, 1'b0, 1'b0);
            send_beat(24'h0000FF, 1'b0, 1'b1);
            send_frame(w, h, w, h, 0, 0, 0, 0);
          end
          3: send_frame(w, h, w, h, 3,
                        $urandom_range(0, w - 1),
                        $urandom_range(0, h - 1), 0);
          default:
            send_frame(w, h, w, h, 0, 0, 0, 0);
        endcase
      end
      stall_tog = 0; gap_en = 0;
      settle();
      cmp_model($sformatf("rand%0d", r));
    end

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
